// File: rtl/d_cache_pkg.sv
// Shared constants and types for the L1 data-cache data array.
package d_cache_pkg;

    localparam int DW    = 64;
    localparam int BYTES = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    // Index width for a count of n items; a single item still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/d_cache_data_array_if.sv
// Read, store and refill signals between the LSU/refill logic and the data array.
interface d_cache_data_array_if
    import d_cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int WORDS = 2,
    parameter int DW    = d_cache_pkg::DW
);
    localparam int SET_W  = idx_w(SETS);
    localparam int WORD_W = idx_w(WORDS);
    localparam int WAY_W  = idx_w(WAYS);

    logic                 rd_en_i;
    logic [SET_W-1:0]     rd_set_i;
    logic [WORD_W-1:0]    rd_word_i;
    logic [WAYS*DW-1:0]   rd_data_o;
    logic                 rd_valid_o;

    logic                 wr_en_i;
    logic [WAY_W-1:0]     wr_way_i;
    logic [SET_W-1:0]     wr_set_i;
    logic [WORD_W-1:0]    wr_word_i;
    logic [DW-1:0]        wr_data_i;
    logic [DW/8-1:0]      wr_strb_i;
    logic                 wr_ready_o;

    logic                 fill_start_i;
    logic [WAY_W-1:0]     fill_way_i;
    logic [SET_W-1:0]     fill_set_i;
    logic                 fill_valid_i;
    logic [DW-1:0]        fill_data_i;
    logic                 fill_ready_o;
    logic                 fill_busy_o;
    logic                 fill_done_o;

    modport master (
        output rd_en_i, rd_set_i, rd_word_i,
        input  rd_data_o, rd_valid_o,
        output wr_en_i, wr_way_i, wr_set_i, wr_word_i, wr_data_i, wr_strb_i,
        input  wr_ready_o,
        output fill_start_i, fill_way_i, fill_set_i, fill_valid_i, fill_data_i,
        input  fill_ready_o, fill_busy_o, fill_done_o
    );

    modport slave (
        input  rd_en_i, rd_set_i, rd_word_i,
        output rd_data_o, rd_valid_o,
        input  wr_en_i, wr_way_i, wr_set_i, wr_word_i, wr_data_i, wr_strb_i,
        output wr_ready_o,
        input  fill_start_i, fill_way_i, fill_set_i, fill_valid_i, fill_data_i,
        output fill_ready_o, fill_busy_o, fill_done_o
    );

endinterface

// File: rtl/d_cache_data_bank.sv
// One way of the data array: SETS*WORDS words, byte-strobed write, registered
// read-first read. Storage is never reset; only the read register is.
module d_cache_data_bank
    import d_cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WORDS = 2,
    parameter int DW    = d_cache_pkg::DW,
    parameter int AW    = idx_w(SETS) + idx_w(WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_strb
);
    logic [DW-1:0] mem [2**AW];

    // Byte-lane write; unstrobed lanes keep their contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Registered read; sees the pre-write word on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/d_cache_data_array.sv
// L1 data-cache data array: WAYS parallel banks, store write port, refill
// sequencer and read path. Optional macro D_CACHE_FWD_EN forwards a same-cycle
// accepted write into the read result; without it reads are read-first.
//
// state | meaning
// IDLE  | no refill in progress, stores accepted
// FILL  | accepting refill beats into the latched way/set, stores blocked
// DONE  | last beat written, fill_done_o high, stores accepted
module d_cache_data_array
    import d_cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int WORDS = 2,
    parameter int DW    = d_cache_pkg::DW
) (
    input logic                clk,
    input logic                rst,
    d_cache_data_array_if.slave bus
);
    localparam int SET_W  = idx_w(SETS);
    localparam int WORD_W = idx_w(WORDS);
    localparam int WAY_W  = idx_w(WAYS);
    localparam int AW     = SET_W + WORD_W;
    localparam int NB     = DW / 8;

    fill_state_t         state_q;
    logic [WORD_W-1:0]   cnt_q;
    logic [WAY_W-1:0]    fill_way_q;
    logic [SET_W-1:0]    fill_set_q;

    logic                store_acc;
    logic                beat_acc;
    logic [WAY_W-1:0]    w_way;
    logic [AW-1:0]       w_addr;
    logic [DW-1:0]       w_data;
    logic [NB-1:0]       w_strb;
    logic [WAYS-1:0]     we;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       bank_q [WAYS];
    logic [WAYS*DW-1:0]  rd_mux;

    assign bus.wr_ready_o = (state_q != FILL);
    assign store_acc      = bus.wr_en_i && bus.wr_ready_o;
    assign beat_acc       = (state_q == FILL) && bus.fill_valid_i;
    assign r_addr         = {bus.rd_set_i, bus.rd_word_i};

    // Write arbitration: refill beats and stores are mutually exclusive by state.
    always_comb begin
        w_way  = beat_acc ? fill_way_q : bus.wr_way_i;
        w_addr = beat_acc ? {fill_set_q, cnt_q} : {bus.wr_set_i, bus.wr_word_i};
        w_data = beat_acc ? bus.fill_data_i : bus.wr_data_i;
        w_strb = beat_acc ? {NB{1'b1}} : bus.wr_strb_i;
        we     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if ((store_acc || beat_acc) && (w_way == WAY_W'(w))) we[w] = 1'b1;
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_bank
        d_cache_data_bank #(
            .SETS  (SETS),
            .WORDS (WORDS),
            .DW    (DW),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (bus.rd_en_i),
            .rd_addr (r_addr),
            .rd_data (bank_q[g]),
            .wr_en   (we[g]),
            .wr_addr (w_addr),
            .wr_data (w_data),
            .wr_strb (w_strb)
        );
    end

    // Refill sequencer with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            fill_way_q       <= '0;
            fill_set_q       <= '0;
            bus.fill_ready_o <= 1'b0;
            bus.fill_busy_o  <= 1'b0;
            bus.fill_done_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bus.fill_done_o <= 1'b0;
                    if (bus.fill_start_i) begin
                        state_q          <= FILL;
                        fill_way_q       <= bus.fill_way_i;
                        fill_set_q       <= bus.fill_set_i;
                        cnt_q            <= '0;
                        bus.fill_ready_o <= 1'b1;
                        bus.fill_busy_o  <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.fill_valid_i) begin
                        if (cnt_q == WORD_W'(WORDS - 1)) begin
                            state_q          <= DONE;
                            cnt_q            <= '0;
                            bus.fill_ready_o <= 1'b0;
                            bus.fill_done_o  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + WORD_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q         <= IDLE;
                    bus.fill_done_o <= 1'b0;
                    bus.fill_busy_o <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read valid follows the request by one cycle.
    always_ff @(posedge clk) begin
        if (rst) bus.rd_valid_o <= 1'b0;
        else     bus.rd_valid_o <= bus.rd_en_i;
    end

`ifdef D_CACHE_FWD_EN
    logic [NB-1:0] fwd_mask_q [WAYS];
    logic [DW-1:0] fwd_data_q;

    // Capture which bytes of each way the colliding write replaced; held with the read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) fwd_mask_q[w] <= '0;
            fwd_data_q <= '0;
        end else if (bus.rd_en_i) begin
            for (int w = 0; w < WAYS; w++) begin
                fwd_mask_q[w] <= (we[w] && (w_addr == r_addr)) ? w_strb : '0;
            end
            fwd_data_q <= w_data;
        end
    end

    // Bank output holds the old word, so overlaying the new bytes yields the merged value.
    always_comb begin
        rd_mux = '0;
        for (int w = 0; w < WAYS; w++) begin
            for (int b = 0; b < NB; b++) begin
                rd_mux[w*DW + b*8 +: 8] = fwd_mask_q[w][b] ? fwd_data_q[b*8 +: 8]
                                                           : bank_q[w][b*8 +: 8];
            end
        end
    end
`else
    // Read-first: bank outputs go straight out.
    always_comb begin
        rd_mux = '0;
        for (int w = 0; w < WAYS; w++) rd_mux[w*DW +: DW] = bank_q[w];
    end
`endif

    assign bus.rd_data_o = rd_mux;

endmodule

// File: tb/tb_d_cache_data_array.sv
// Directed bench for d_cache_data_array (WAYS=2, SETS=64, WORDS=2).
module tb_d_cache_data_array;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   done_base;

    always #5 clk = ~clk;

    d_cache_data_array_if #(.WAYS(2), .SETS(64), .WORDS(2), .DW(64)) bus ();

    d_cache_data_array #(.WAYS(2), .SETS(64), .WORDS(2), .DW(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.fill_done_o === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rd_en_i      = 1'b0;
        bus.rd_set_i     = '0;
        bus.rd_word_i    = '0;
        bus.wr_en_i      = 1'b0;
        bus.wr_way_i     = '0;
        bus.wr_set_i     = '0;
        bus.wr_word_i    = '0;
        bus.wr_data_i    = '0;
        bus.wr_strb_i    = '0;
        bus.fill_start_i = 1'b0;
        bus.fill_way_i   = '0;
        bus.fill_set_i   = '0;
        bus.fill_valid_i = 1'b0;
        bus.fill_data_i  = '0;
    endtask

    task automatic set_store(input int way, input int set, input int word,
                             input logic [63:0] data, input logic [7:0] strb);
        bus.wr_en_i   = 1'b1;
        bus.wr_way_i  = 1'(way);
        bus.wr_set_i  = 6'(set);
        bus.wr_word_i = 1'(word);
        bus.wr_data_i = data;
        bus.wr_strb_i = strb;
    endtask

    task automatic store(input int way, input int set, input int word,
                         input logic [63:0] data, input logic [7:0] strb);
        set_store(way, set, word, data, strb);
        tick();
        bus.wr_en_i = 1'b0;
    endtask

    task automatic read(input int set, input int word);
        bus.rd_en_i   = 1'b1;
        bus.rd_set_i  = 6'(set);
        bus.rd_word_i = 1'(word);
        tick();
        bus.rd_en_i = 1'b0;
    endtask

    task automatic start_fill(input int way, input int set);
        bus.fill_start_i = 1'b1;
        bus.fill_way_i   = 1'(way);
        bus.fill_set_i   = 6'(set);
        tick();
        bus.fill_start_i = 1'b0;
    endtask

    task automatic beat(input logic [63:0] data);
        bus.fill_valid_i = 1'b1;
        bus.fill_data_i  = data;
        tick();
        bus.fill_valid_i = 1'b0;
    endtask

    function automatic logic [63:0] way_data(input int w);
        return bus.rd_data_o[w*64 +: 64];
    endfunction

    initial begin
        clear_inputs();

        // Reset
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_rd_data_w0", way_data(0), 64'h0);
        check_eq("rst_rd_data_w1", way_data(1), 64'h0);
        check_eq("rst_rd_valid", 64'(bus.rd_valid_o), 64'h0);
        check_eq("rst_fill_ready", 64'(bus.fill_ready_o), 64'h0);
        check_eq("rst_fill_busy", 64'(bus.fill_busy_o), 64'h0);
        check_eq("rst_fill_done", 64'(bus.fill_done_o), 64'h0);
        check_eq("rst_wr_ready", 64'(bus.wr_ready_o), 64'h1);
        rst = 1'b0;
        tick();

        // Strobed store
        store(1, 5, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        store(0, 5, 1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        store(1, 5, 1, 64'h1122_3344_5566_7788, 8'h0F);
        read(5, 1);
        check_eq("strb_w1", way_data(1), 64'hFFFF_FFFF_5566_7788);
        check_eq("strb_w0", way_data(0), 64'h0123_4567_89AB_CDEF);
        check_eq("strb_valid", 64'(bus.rd_valid_o), 64'h1);
        tick();
        check_eq("hold_valid", 64'(bus.rd_valid_o), 64'h0);
        check_eq("hold_w1", way_data(1), 64'hFFFF_FFFF_5566_7788);

        // Back-to-back fill way0/set63
        done_base = done_cnt;
        start_fill(0, 63);
        check_eq("fill_busy", 64'(bus.fill_busy_o), 64'h1);
        check_eq("fill_ready", 64'(bus.fill_ready_o), 64'h1);
        check_eq("fill_wr_ready", 64'(bus.wr_ready_o), 64'h0);
        beat(64'hA);
        check_eq("fill_done_early", 64'(bus.fill_done_o), 64'h0);
        beat(64'hB);
        check_eq("fill_done", 64'(bus.fill_done_o), 64'h1);
        check_eq("done_ready", 64'(bus.fill_ready_o), 64'h0);
        check_eq("done_wr_ready", 64'(bus.wr_ready_o), 64'h1);
        tick();
        check_eq("post_done", 64'(bus.fill_done_o), 64'h0);
        check_eq("post_busy", 64'(bus.fill_busy_o), 64'h0);
        check_eq("done_pulses", 64'(done_cnt - done_base), 64'h1);
        read(63, 0);
        check_eq("fill_word0", way_data(0), 64'hA);
        read(63, 1);
        check_eq("fill_word1", way_data(0), 64'hB);

        // Blocked store during fill, completed in DONE
        store(1, 20, 0, 64'h7777_7777_7777_7777, 8'hFF);
        start_fill(1, 10);
        set_store(1, 20, 0, 64'hDEAD_BEEF_0000_1234, 8'hFF);
        check_eq("blk_wr_ready", 64'(bus.wr_ready_o), 64'h0);
        tick();
        read(20, 0);
        check_eq("blk_unchanged", way_data(1), 64'h7777_7777_7777_7777);
        beat(64'hC0);
        beat(64'hC1);
        check_eq("blk_done_ready", 64'(bus.wr_ready_o), 64'h1);
        tick();
        bus.wr_en_i = 1'b0;
        read(20, 0);
        check_eq("blk_written", way_data(1), 64'hDEAD_BEEF_0000_1234);
        read(10, 1);
        check_eq("blk_fill_w1", way_data(1), 64'hC1);

        // Same-cycle read and write
        store(0, 7, 0, 64'h1111_1111_1111_1111, 8'hFF);
        set_store(0, 7, 0, 64'h2222_2222_2222_2222, 8'h0F);
        read(7, 0);
        bus.wr_en_i = 1'b0;
`ifdef D_CACHE_FWD_EN
        check_eq("rdw_same", way_data(0), 64'h1111_1111_2222_2222);
`else
        check_eq("rdw_same", way_data(0), 64'h1111_1111_1111_1111);
`endif
        read(7, 0);
        check_eq("rdw_after", way_data(0), 64'h1111_1111_2222_2222);

        // Reset mid-fill
        done_base = done_cnt;
        start_fill(1, 3);
        beat(64'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_busy", 64'(bus.fill_busy_o), 64'h0);
        check_eq("mrst_ready", 64'(bus.fill_ready_o), 64'h0);
        check_eq("mrst_wr_ready", 64'(bus.wr_ready_o), 64'h1);
        tick();
        tick();
        check_eq("mrst_no_done", 64'(done_cnt - done_base), 64'h0);
        read(3, 0);
        check_eq("mrst_word0_kept", way_data(1), 64'h99);
        start_fill(1, 3);
        beat(64'hE0);
        beat(64'hE1);
        check_eq("refill_done", 64'(bus.fill_done_o), 64'h1);
        tick();
        read(3, 0);
        check_eq("refill_w0", way_data(1), 64'hE0);
        read(3, 1);
        check_eq("refill_w1", way_data(1), 64'hE1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
